sd_host_shifter: RTL and testbench
==================================

# sd_host_shifter

Parametrised SD-card host port for the Rv32H peripheral bus. It keeps the bit-bang pin register of the earlier SD port for card initialisation and slow paths. It adds a programmable SD_CLK divider and a hardware shift engine that clocks up to 64 SD_CLK cycles of serial data on CMD (1 bit per cycle) or DAT (4 bits per cycle) without CPU involvement. It sits on the CPU peripheral bus behind the address decoder.

## Interface
- DIV_WIDTH, 8: width of the SD_CLK half-period divider register.
- SHIFT_WIDTH, 32: width of the TX and RX shift registers; must be a multiple of 4 and at least 8.
- i_clock  in  1  system clock; single clock domain.
- i_reset  in  1  reset, synchronous and active-high.
- i_request  in  1  bus access strobe, one access per asserted cycle.
- i_rw  in  1  1 = write, 0 = read.
- i_address  in  2  register select: 0 PINS, 1 DIV, 2 DATA, 3 CTRL.
- i_wdata  in  32  write data.
- o_rdata  out  32  read data, registered.
- o_ready  out  1  access acknowledge.
- SD_CLK  out  1  card clock.
- SD_CMD  inout  1  command line, tri-stated when cdir = 0.
- SD_DAT  inout  4  data lines, tri-stated when ddir = 0.

## Operation
- State registers: clk, cdir, ddir, cmd, dat[3:0], div, tx, rx, cnt[5:0], lane, state.
- **PINS (0)**
  - Read: {24'b0, dat_v, cmd_v, ddir, cdir, clk}. dat_v/cmd_v is the pad value when the direction bit is 0, otherwise the driven register.
  - Write: for each bit b of {dat, cmd, ddir, cdir, clk}, reg = (reg & ~i_wdata[8+b]) | i_wdata[b]. Bits [7:0] are value, bits [15:8] are mask.
  - While busy, writes to PINS update only cdir/ddir; clk/cmd/dat writes are dropped.
- **DIV (1)**: R/W div = i_wdata[DIV_WIDTH-1:0]. Each SD_CLK half-period in shift mode lasts div+1 i_clock cycles.
- **DATA (2)**
  - Write loads tx when idle and is ignored when busy.
  - Read returns rx, zero-extended or truncated to 32 bits.
- **CTRL (3)**
  - Write when idle starts a transfer: cnt = i_wdata[5:0] (SD_CLK cycles = cnt+1), lane = i_wdata[8] (0 CMD, 1 DAT).
  - Write when busy is ignored.
  - Read: {16'b0, 2'b0, cnt, 7'b0, busy}, where busy = (state != IDLE).
- **States**: IDLE, LOW, HIGH. Half-period counter hc counts 0..div.
- **IDLE → LOW** on start: clk <= 0, hc <= 0. Drive the first symbol:
  - lane 0: cmd <= tx[MSB].
  - lane 1: dat <= tx[MSB-:4].
- **LOW**: when hc == div, go to HIGH, clk <= 1, hc <= 0, and sample the pad on this rising edge:
  - lane 0: rx <= {rx, cmd_in}.
  - lane 1: rx <= {rx, dat_in}.
- **HIGH**: when hc == div, clk <= 0, hc <= 0.
  - If cnt == 0, go to IDLE.
  - Otherwise: cnt <= cnt-1; shift tx left by 1 (lane 0) or 4 (lane 1), filling with 1s; drive the next symbol; go to LOW.
- Output changes happen only on SD_CLK falling edges; sampling happens only on rising edges.
- Lines are driven only if the matching dir bit is 1. The engine updates cmd/dat registers regardless of direction, so a receive-only transfer leaves dir = 0.
- After IDLE: clk = 0, cmd/dat hold the last symbol, tx holds the shifted remainder.
- Transfers longer than SHIFT_WIDTH bits transmit 1s once tx is exhausted. rx keeps the last SHIFT_WIDTH bits received.

## Timing
- Reset values: clk 0, cdir 0, ddir 0, cmd 1, dat 4'hF, div 0, tx 0, rx 0, cnt 0, lane 0, state IDLE, o_rdata 0, o_ready 0.
- o_ready = i_request delayed one cycle, for every access regardless of address or busy. o_rdata is valid in the same cycle o_ready is high.
- The CTRL write is sampled at edge T. busy reads 1 from access T+1, and the first symbol is on the pad after edge T.
- First SD_CLK rise at edge T+(div+1). One SD_CLK period is 2·(div+1) i_clock cycles.
- A transfer of cnt+1 cycles is IDLE again after edge T+2·(div+1)·(cnt+1).
- A simultaneous CTRL start and any other access is impossible; there is one access per cycle.
- Reset asserted mid-transfer: all registers return to reset values at the next edge, SD_CLK goes low, and both lines release in that cycle.
- Changing div mid-transfer takes effect at the next half-period boundary (hc compare uses the live div).

## Test plan
- Reset check: after reset, read PINS → 0x000000F8 with pads pulled up, and o_ready one cycle after i_request.
- PINS bit-bang: write 0x0000_0F0A → cdir = 1, cmd = 1, clk = 0. Read back bits [4:0] = 0b11010 and SD_CMD driven 1. Write 0x0000_0100 → clk = 0, no change.
- CMD transmit: div = 1, cdir = 1, DATA = 0x4000_0000, CTRL = 0x007 (8 cycles) → SD_CMD bits 0,1,0,0,0,0,0,0 change only on SD_CLK falls. SD_CLK period is 4 clocks. busy clears 32 clocks after start.
- DAT receive: ddir = 0, pads driven 0xA,0x5,0xF,0x0,… by the bench on SD_CLK falls, CTRL = 0x107 (8 cycles, DAT) → rx = 0xA5F0_xxxx with 8 nibbles matching the stimulus.
- Busy protection: during a transfer, write DATA 0xFFFF_FFFF and CTRL 0x03F → tx and cnt unaffected, transfer length unchanged. A PINS write of clk is dropped.
- Reset mid-transfer: assert i_reset for 1 cycle while state is HIGH → next cycle SD_CLK = 0, SD_CMD/SD_DAT high-Z, CTRL busy reads 0.

Source files
------------

// File: rtl/sd_host_shifter_if.sv
// sd_host_shifter_if
// Peripheral bus bundle between the CPU address decoder and the SD host port.
//   i_request  access strobe, one access per asserted cycle
//   i_rw       1 = write, 0 = read
//   i_address  register select: 0 PINS, 1 DIV, 2 DATA, 3 CTRL
//   i_wdata    write data
//   o_rdata    registered read data, valid while o_ready is high
//   o_ready    access acknowledge, i_request delayed by one cycle
interface sd_host_shifter_if;
    logic        i_request;
    logic        i_rw;
    logic [1:0]  i_address;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_ready;

    modport master (
        output i_request,
        output i_rw,
        output i_address,
        output i_wdata,
        input  o_rdata,
        input  o_ready
    );

    modport slave (
        input  i_request,
        input  i_rw,
        input  i_address,
        input  i_wdata,
        output o_rdata,
        output o_ready
    );
endinterface

// File: rtl/sd_host_shifter.sv
// sd_host_shifter
// SD-card host port: bit-bang pin register, programmable SD_CLK divider and a
// shift engine clocking up to 64 SD_CLK cycles on CMD (1 bit) or DAT (4 bits).
//   i_clock  system clock
//   i_reset  synchronous active-high reset
//   bus      peripheral bus slave (see sd_host_shifter_if)
//   SD_CLK   card clock
//   SD_CMD   command line, driven only while cdir = 1
//   SD_DAT   data lines, driven only while ddir = 1
module sd_host_shifter #(
    parameter int unsigned DIV_WIDTH   = 8,
    parameter int unsigned SHIFT_WIDTH = 32
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    sd_host_shifter_if.slave     bus,
    output logic                 SD_CLK,
    inout  wire                  SD_CMD,
    inout  wire  [3:0]           SD_DAT
);

    typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;

    state_e                 state_q, state_d;
    logic                   clk_q, clk_d;
    logic                   cdir_q, cdir_d;
    logic                   ddir_q, ddir_d;
    logic                   cmd_q, cmd_d;
    logic [3:0]             dat_q, dat_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [DIV_WIDTH-1:0]   hc_q, hc_d;
    logic [SHIFT_WIDTH-1:0] tx_q, tx_d;
    logic [SHIFT_WIDTH-1:0] rx_q, rx_d;
    logic [5:0]             cnt_q, cnt_d;
    logic                   lane_q, lane_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   ready_q, ready_d;

    logic                   cmd_in;
    logic [3:0]             dat_in;
    logic                   cmd_v;
    logic [3:0]             dat_v;
    logic                   busy;
    logic                   start;
    logic [7:0]             pins_cur;
    logic [7:0]             pins_wr;
    logic [SHIFT_WIDTH-1:0] tx_nx;

    assign cmd_in = SD_CMD;
    assign dat_in = SD_DAT;

    // Readback shows the pad when the line is released, else the driven value.
    assign cmd_v = cdir_q ? cmd_q : cmd_in;
    assign dat_v = ddir_q ? dat_q : dat_in;

    assign busy = (state_q != StIdle);

    assign pins_cur = {dat_q, cmd_q, ddir_q, cdir_q, clk_q};
    // Bits [15:8] clear, bits [7:0] set.
    assign pins_wr  = (pins_cur & ~bus.i_wdata[15:8]) | bus.i_wdata[7:0];

    always_comb begin
        state_d = state_q;
        clk_d   = clk_q;
        cdir_d  = cdir_q;
        ddir_d  = ddir_q;
        cmd_d   = cmd_q;
        dat_d   = dat_q;
        div_d   = div_q;
        hc_d    = hc_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        rdata_d = rdata_q;
        ready_d = bus.i_request;
        start   = 1'b0;
        tx_nx   = tx_q;

        if (bus.i_request && !bus.i_rw) begin
            unique case (bus.i_address)
                2'd0:    rdata_d = {24'b0, dat_v, cmd_v, ddir_q, cdir_q, clk_q};
                2'd1:    rdata_d = 32'(div_q);
                2'd2:    rdata_d = 32'(rx_q);
                default: rdata_d = {18'b0, cnt_q, 7'b0, busy};
            endcase
        end

        if (bus.i_request && bus.i_rw) begin
            unique case (bus.i_address)
                2'd0: begin
                    // The engine owns clk/cmd/dat while a transfer runs.
                    cdir_d = pins_wr[1];
                    ddir_d = pins_wr[2];
                    if (!busy) begin
                        clk_d = pins_wr[0];
                        cmd_d = pins_wr[3];
                        dat_d = pins_wr[7:4];
                    end
                end
                2'd1: div_d = bus.i_wdata[DIV_WIDTH-1:0];
                2'd2: if (!busy) tx_d = SHIFT_WIDTH'(bus.i_wdata);
                default: start = !busy;
            endcase
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d   = bus.i_wdata[5:0];
                    lane_d  = bus.i_wdata[8];
                    state_d = StLow;
                    clk_d   = 1'b0;
                    hc_d    = '0;
                    if (bus.i_wdata[8]) begin
                        dat_d = tx_q[SHIFT_WIDTH-1 -: 4];
                    end else begin
                        cmd_d = tx_q[SHIFT_WIDTH-1];
                    end
                end
            end
            StLow: begin
                if (hc_q == div_q) begin
                    state_d = StHigh;
                    clk_d   = 1'b1;
                    hc_d    = '0;
                    if (lane_q) begin
                        rx_d = {rx_q[SHIFT_WIDTH-5:0], dat_in};
                    end else begin
                        rx_d = {rx_q[SHIFT_WIDTH-2:0], cmd_in};
                    end
                end else begin
                    hc_d = hc_q + DIV_WIDTH'(1);
                end
            end
            StHigh: begin
                if (hc_q == div_q) begin
                    clk_d = 1'b0;
                    hc_d  = '0;
                    if (cnt_q == 6'd0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d   = cnt_q - 6'd1;
                        state_d = StLow;
                        // Exhausted tx keeps sending 1s.
                        if (lane_q) begin
                            tx_nx = {tx_q[SHIFT_WIDTH-5:0], 4'hF};
                            dat_d = tx_nx[SHIFT_WIDTH-1 -: 4];
                        end else begin
                            tx_nx = {tx_q[SHIFT_WIDTH-2:0], 1'b1};
                            cmd_d = tx_nx[SHIFT_WIDTH-1];
                        end
                        tx_d = tx_nx;
                    end
                end else begin
                    hc_d = hc_q + DIV_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= StIdle;
            clk_q   <= 1'b0;
            cdir_q  <= 1'b0;
            ddir_q  <= 1'b0;
            cmd_q   <= 1'b1;
            dat_q   <= 4'hF;
            div_q   <= '0;
            hc_q    <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            lane_q  <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clk_q   <= clk_d;
            cdir_q  <= cdir_d;
            ddir_q  <= ddir_d;
            cmd_q   <= cmd_d;
            dat_q   <= dat_d;
            div_q   <= div_d;
            hc_q    <= hc_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    assign bus.o_rdata = rdata_q;
    assign bus.o_ready = ready_q;
    assign SD_CLK      = clk_q;
    assign SD_CMD      = cdir_q ? cmd_q : 1'bz;
    assign SD_DAT      = ddir_q ? dat_q : 4'bzzzz;

endmodule

// File: tb/tb_sd_host_shifter.sv
// tb_sd_host_shifter
// Directed bench for sd_host_shifter: reset state, bit-bang pins, CMD transmit,
// DAT receive, busy protection and reset during a transfer.
module tb_sd_host_shifter;

    logic       clk = 1'b0;
    logic       rst;
    logic       tb_cmd_oe;
    logic       tb_cmd;
    logic       tb_dat_oe;
    logic [3:0] tb_dat;
    wire        sd_cmd;
    wire  [3:0] sd_dat;
    logic       sd_clk;

    int checks   = 0;
    int failures = 0;

    logic        pend;
    logic [31:0] pend_exp;
    logic [3:0]  nibs [8];

    sd_host_shifter_if bus ();

    sd_host_shifter #(
        .DIV_WIDTH   (8),
        .SHIFT_WIDTH (32)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus),
        .SD_CLK  (sd_clk),
        .SD_CMD  (sd_cmd),
        .SD_DAT  (sd_dat)
    );

    // Card-side drivers.
    assign sd_cmd = tb_cmd_oe ? tb_cmd : 1'bz;
    assign sd_dat = tb_dat_oe ? tb_dat : 4'bzzzz;

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.i_request = 1'b1;
        bus.i_rw      = 1'b1;
        bus.i_address = a;
        bus.i_wdata   = d;
        @(negedge clk);
        bus.i_request = 1'b0;
        bus.i_rw      = 1'b0;
    endtask

    task automatic bus_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        @(negedge clk);
        check32({tag, "_rdy_pre"}, {31'b0, bus.o_ready}, 32'd0);
        bus.i_request = 1'b1;
        bus.i_rw      = 1'b0;
        bus.i_address = a;
        @(negedge clk);
        bus.i_request = 1'b0;
        check32({tag, "_rdy"}, {31'b0, bus.o_ready}, 32'd1);
        check32(tag, bus.o_rdata, exp);
    endtask

    // Starts an access without waiting; the caller advances the clock.
    task automatic issue(input logic rw, input logic [1:0] a, input logic [31:0] d);
        bus.i_request = 1'b1;
        bus.i_rw      = rw;
        bus.i_address = a;
        bus.i_wdata   = d;
    endtask

    initial begin
        bus.i_request = 1'b0;
        bus.i_rw      = 1'b0;
        bus.i_address = 2'd0;
        bus.i_wdata   = 32'd0;
        tb_cmd_oe = 1'b1;
        tb_cmd    = 1'b1;
        tb_dat_oe = 1'b1;
        tb_dat    = 4'hF;
        pend      = 1'b0;
        pend_exp  = 32'd0;
        nibs = '{4'hA, 4'h5, 4'hF, 4'h0, 4'h3, 4'hC, 4'h9, 4'h6};

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check32("rst_clk", {31'b0, sd_clk}, 32'd0);
        check32("rst_ready", {31'b0, bus.o_ready}, 32'd0);
        bus_rd("rst_pins", 2'd0, 32'h0000_00F8);
        bus_rd("rst_div", 2'd1, 32'd0);
        bus_rd("rst_data", 2'd2, 32'd0);
        bus_rd("rst_ctrl", 2'd3, 32'd0);

        // Bit-bang pins.
        tb_cmd_oe = 1'b0;
        bus_wr(2'd0, 32'h0000_0F0A);
        bus_rd("pins_cdir", 2'd0, 32'h0000_00FA);
        check32("pins_cmd_drv", {31'b0, sd_cmd}, 32'd1);
        bus_wr(2'd0, 32'h0000_0100);
        bus_rd("pins_clr_clk", 2'd0, 32'h0000_00FA);
        bus_wr(2'd0, 32'h0000_0001);
        check32("pins_clk_hi", {31'b0, sd_clk}, 32'd1);
        bus_rd("pins_set_clk", 2'd0, 32'h0000_00FB);
        bus_wr(2'd0, 32'h0000_0100);
        check32("pins_clk_lo", {31'b0, sd_clk}, 32'd0);
        bus_wr(2'd0, 32'h0000_0800);
        check32("pins_cmd0", {31'b0, sd_cmd}, 32'd0);
        bus_rd("pins_cmd0_rd", 2'd0, 32'h0000_00F2);
        bus_wr(2'd0, 32'h0000_0008);
        bus_rd("pins_cmd1_rd", 2'd0, 32'h0000_00FA);

        // CMD transmit: div = 1, 8 cycles of 0x40 MSB first.
        bus_wr(2'd1, 32'd1);
        bus_rd("div_rd", 2'd1, 32'd1);
        bus_wr(2'd2, 32'h4000_0000);
        bus_wr(2'd3, 32'h0000_0007);
        for (int m = 0; m < 34; m++) begin
            if (m < 32) begin
                check32("tx_clk", {31'b0, sd_clk}, 32'((m >> 1) & 1));
                check32("tx_cmd", {31'b0, sd_cmd}, {31'b0, ((m >> 2) == 1)});
            end
            if (pend) begin
                check32("tx_ctrl_rdy", {31'b0, bus.o_ready}, 32'd1);
                check32("tx_ctrl", bus.o_rdata, pend_exp);
                pend = 1'b0;
            end
            bus.i_request = 1'b0;
            if (m == 1) begin
                issue(1'b0, 2'd3, 32'd0); pend = 1'b1; pend_exp = 32'h0000_0701;
            end else if (m == 31) begin
                issue(1'b0, 2'd3, 32'd0); pend = 1'b1; pend_exp = 32'h0000_0001;
            end else if (m == 32) begin
                issue(1'b0, 2'd3, 32'd0); pend = 1'b1; pend_exp = 32'h0000_0000;
            end
            @(negedge clk);
        end
        bus.i_request = 1'b0;
        bus_rd("tx_rx", 2'd2, 32'h0000_0040);

        // DAT receive: the bench drives nibbles, advancing on SD_CLK falls.
        tb_dat = nibs[0];
        bus_wr(2'd3, 32'h0000_0107);
        for (int m = 0; m < 34; m++) begin
            if (m < 32) begin
                check32("rx_clk", {31'b0, sd_clk}, 32'((m >> 1) & 1));
                check32("rx_pad", {28'b0, sd_dat}, {28'b0, tb_dat});
                if (m > 0 && (m % 4) == 0) tb_dat = nibs[m / 4];
            end
            if (pend) begin
                check32("rx_ctrl", bus.o_rdata, pend_exp);
                pend = 1'b0;
            end
            bus.i_request = 1'b0;
            if (m == 32) begin
                issue(1'b0, 2'd3, 32'd0); pend = 1'b1; pend_exp = 32'h0000_0000;
            end
            @(negedge clk);
        end
        bus.i_request = 1'b0;
        bus_rd("rx_data", 2'd2, 32'hA5F0_3C96);

        // Busy protection: 4 CMD cycles of 1,0,0,0 with writes during the transfer.
        tb_dat = 4'hF;
        bus_wr(2'd2, 32'h8000_0000);
        bus_wr(2'd3, 32'h0000_0003);
        for (int m = 0; m < 18; m++) begin
            if (m < 16) begin
                check32("bz_clk", {31'b0, sd_clk}, 32'((m >> 1) & 1));
                check32("bz_cmd", {31'b0, sd_cmd}, {31'b0, ((m >> 2) == 0)});
            end
            if (pend) begin
                check32("bz_ctrl", bus.o_rdata, pend_exp);
                pend = 1'b0;
            end
            bus.i_request = 1'b0;
            if (m == 0) issue(1'b1, 2'd0, 32'h0000_0001);
            else if (m == 1) issue(1'b1, 2'd2, 32'hFFFF_FFFF);
            else if (m == 2) issue(1'b1, 2'd3, 32'h0000_003F);
            else if (m == 15) begin
                issue(1'b0, 2'd3, 32'd0); pend = 1'b1; pend_exp = 32'h0000_0001;
            end else if (m == 16) begin
                issue(1'b0, 2'd3, 32'd0); pend = 1'b1; pend_exp = 32'h0000_0000;
            end
            @(negedge clk);
        end
        bus.i_request = 1'b0;
        bus.i_rw      = 1'b0;
        bus_rd("bz_rx", 2'd2, 32'h5F03_C968);
        bus_rd("bz_pins", 2'd0, 32'h0000_00F2);

        // Reset while SD_CLK is high.
        tb_dat_oe = 1'b0;
        bus_wr(2'd0, 32'h0000_0404);
        bus_wr(2'd3, 32'h0000_000F);
        begin
            int w = 0;
            while (sd_clk !== 1'b1 && w < 10) begin
                @(negedge clk);
                w++;
            end
        end
        check32("mr_wait_high", {31'b0, sd_clk}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tb_cmd_oe = 1'b1;
        tb_cmd    = 1'b0;
        tb_dat_oe = 1'b1;
        tb_dat    = 4'h0;
        #1;
        check32("mr_clk", {31'b0, sd_clk}, 32'd0);
        check32("mr_cmd_rel", {31'b0, sd_cmd}, 32'd0);
        check32("mr_dat_rel", {28'b0, sd_dat}, 32'd0);
        bus_rd("mr_ctrl", 2'd3, 32'd0);
        bus_rd("mr_pins", 2'd0, 32'd0);
        bus_rd("mr_div", 2'd1, 32'd0);
        bus_rd("mr_data", 2'd2, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
